// File: rtl/nn_pkg.sv
// Shared constants and types for the neural network core: fixed-point format,
// output-reader FSM states and an address-width helper.
package nn_pkg;

  localparam int FRAC_BITS = 4;
  localparam int ONE       = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } rd_state_t;

  // Smallest address width able to index n words; never below 1 bit.
  function automatic int addr_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nn_argmax_tracker.sv
// Running signed maximum and its index over one drain; committed result is
// published when the final word is accepted.
module nn_argmax_tracker
  import nn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     update,
  input  logic                     commit,
  input  logic signed [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0]        index,
  output logic                     class_valid,
  output logic [ADDR_W-1:0]        class_index,
  output logic signed [DATA_W-1:0] class_value
);

  logic signed [DATA_W-1:0] max_q;
  logic [ADDR_W-1:0]        idx_q;
  logic                     take;
  logic signed [DATA_W-1:0] cand_val;
  logic [ADDR_W-1:0]        cand_idx;

  // Strictly-greater replacement keeps the lowest index on ties.
  assign take     = update && ((index == '0) || (data > max_q));
  assign cand_val = take ? data  : max_q;
  assign cand_idx = take ? index : idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q       <= '0;
      idx_q       <= '0;
      class_valid <= 1'b0;
      class_index <= '0;
      class_value <= '0;
    end else begin
      class_valid <= commit;
      if (clear) begin
        max_q <= '0;
        idx_q <= '0;
      end else if (update) begin
        max_q <= cand_val;
        idx_q <= cand_idx;
      end
      if (commit) begin
        class_index <= cand_idx;
        class_value <= cand_val;
      end
    end
  end

endmodule

// File: rtl/nn_output_reader.sv
// Drains the network output RAM after each inference and streams it over valid/ready.
// Define NN_OUT_ARGMAX_EN to add the class_valid/class_index/class_value argmax outputs.
module nn_output_reader
  import nn_pkg::*;
#(
  parameter int N_OUT  = 1,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ack_network,
  output logic                     mem_trig_r,
  output logic [ADDR_W-1:0]        mem_abus_r,
  input  logic signed [DATA_W-1:0] mem_dbus_r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
`ifdef NN_OUT_ARGMAX_EN
  ,
  output logic                     class_valid,
  output logic [ADDR_W-1:0]        class_index,
  output logic signed [DATA_W-1:0] class_value
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_OUT - 1);

  rd_state_t         state_q, state_d;
  logic              ack_q;
  logic              ack_rise;
  logic              hs;
  logic              final_hs;
  logic [ADDR_W-1:0] idx_q;

  assign ack_rise   = ack_network & ~ack_q;
  assign hs         = (state_q == SEND) & out_ready;
  assign final_hs   = hs & (idx_q == LAST_IDX);
  assign mem_trig_r = (state_q == READ);
  assign mem_abus_r = idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (ack_rise) state_d = READ;
      READ:    state_d = WAIT;
      WAIT:    state_d = SEND;
      SEND:    if (hs) state_d = final_hs ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ack_q <= ack_network;
      done  <= final_hs;
      if (ack_rise && (state_q != IDLE)) overrun <= 1'b1;
      case (state_q)
        IDLE: if (ack_rise) begin
          busy  <= 1'b1;
          idx_q <= '0;
        end
        WAIT: begin
          out_data  <= mem_dbus_r;
          out_index <= idx_q;
          out_last  <= (idx_q == LAST_IDX);
          out_valid <= 1'b1;
        end
        SEND: if (hs) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (!final_hs) idx_q <= idx_q + 1'b1;
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef NN_OUT_ARGMAX_EN
  nn_argmax_tracker #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_argmax (
    .clk         (clk),
    .rst         (rst),
    .clear       (ack_rise && (state_q == IDLE)),
    .update      (hs),
    .commit      (final_hs),
    .data        (out_data),
    .index       (out_index),
    .class_valid (class_valid),
    .class_index (class_index),
    .class_value (class_value)
  );
`endif

endmodule

// File: tb/tb_nn_output_reader.sv
// Self-checking bench: one N_OUT=1 reader and one N_OUT=4 reader against a
// behavioural model of the drained stream, argmax and overrun flag.
module tb_nn_output_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N_OUT = 1 instance
  logic              ack1, rdy1, trig1, valid1, last1, busy1, done1, ovr1;
  logic [0:0]        abus1, idx1;
  logic signed [7:0] dbus1 = '0;
  logic signed [7:0] data1;
  logic signed [7:0] mem1 [2];

  // N_OUT = 4 instance
  logic              ack4, rdy4, trig4, valid4, last4, busy4, done4, ovr4;
  logic [1:0]        abus4, idx4;
  logic signed [7:0] dbus4 = '0;
  logic signed [7:0] data4;
  logic signed [7:0] mem4 [4];

`ifdef NN_OUT_ARGMAX_EN
  logic              cv1, cv4;
  logic [0:0]        ci1;
  logic [1:0]        ci4;
  logic signed [7:0] cval1, cval4;
`endif

  nn_output_reader #(.N_OUT(1), .DATA_W(8), .ADDR_W(1)) dut1 (
    .clk(clk), .rst(rst), .ack_network(ack1), .mem_trig_r(trig1), .mem_abus_r(abus1),
    .mem_dbus_r(dbus1), .out_valid(valid1), .out_ready(rdy1), .out_data(data1),
    .out_index(idx1), .out_last(last1), .busy(busy1), .done(done1), .overrun(ovr1)
`ifdef NN_OUT_ARGMAX_EN
    , .class_valid(cv1), .class_index(ci1), .class_value(cval1)
`endif
  );

  nn_output_reader #(.N_OUT(4), .DATA_W(8), .ADDR_W(2)) dut4 (
    .clk(clk), .rst(rst), .ack_network(ack4), .mem_trig_r(trig4), .mem_abus_r(abus4),
    .mem_dbus_r(dbus4), .out_valid(valid4), .out_ready(rdy4), .out_data(data4),
    .out_index(idx4), .out_last(last4), .busy(busy4), .done(done4), .overrun(ovr4)
`ifdef NN_OUT_ARGMAX_EN
    , .class_valid(cv4), .class_index(ci4), .class_value(cval4)
`endif
  );

  // Output RAM model: read data updates on the falling edge while the strobe is high.
  always @(negedge clk) begin
    if (trig1) dbus1 <= mem1[abus1];
    if (trig4) dbus4 <= mem4[abus4];
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit ov_exp  = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One full drain of the 4-word instance. stall_word/stall_len hold out_ready low on
  // one word; ovr_mid re-raises ack_network while word 2 is on offer.
  task automatic drain4(input int stall_word, input int stall_len,
                        input bit rand_stall, input bit ovr_mid);
    int exp_idx;
    int exp_max;
    int stall;
    int t;
    exp_idx = 0;
    exp_max = mem4[0];
    for (int i = 1; i < 4; i++)
      if (int'(mem4[i]) > exp_max) begin
        exp_max = mem4[i];
        exp_idx = i;
      end

    ack4 = 1'b0;
    rdy4 = 1'b0;
    @(negedge clk);
    ack4 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      t = 0;
      while (!valid4 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!valid4) begin
        check("valid_timeout", 0, 1);
        return;
      end
      if (ovr_mid && w == 1) ack4 = 1'b0;
      if (ovr_mid && w == 2) begin
        ack4   = 1'b1;
        ov_exp = 1'b1;
      end
      check("data", data4, mem4[w]);
      check("index", idx4, w);
      check("last", last4, (w == 3) ? 1 : 0);
      stall = (w == stall_word) ? stall_len : (rand_stall ? int'($urandom_range(0, 3)) : 0);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("hold_valid", valid4, 1);
        check("hold_data", data4, mem4[w]);
        check("hold_index", idx4, w);
      end
      rdy4 = 1'b1;
      @(negedge clk);
      rdy4 = 1'b0;
    end
    check("done_pulse", done4, 1);
    check("busy_at_done", busy4, 1);
    check("valid_at_done", valid4, 0);
`ifdef NN_OUT_ARGMAX_EN
    check("class_valid", cv4, 1);
    check("class_index", ci4, exp_idx);
    check("class_value", cval4, exp_max);
`endif
    @(negedge clk);
    check("done_clear", done4, 0);
    check("busy_clear", busy4, 0);
`ifdef NN_OUT_ARGMAX_EN
    check("class_valid_clear", cv4, 0);
    check("class_index_hold", ci4, exp_idx);
`endif
    check("overrun", ovr4, ov_exp);
  endtask

  initial begin
    int busy_seen;
    rst  = 1'b1;
    ack1 = 1'b0;
    rdy1 = 1'b0;
    ack4 = 1'b0;
    rdy4 = 1'b0;
    mem1[0] = 8'sd16;
    mem1[1] = 8'sd0;
    #1;
    check("rst_valid", valid4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_overrun", ovr4, 0);
    check("rst_trig", trig4, 0);
    check("rst_abus", abus4, 0);
    check("rst_data", data4, 0);
    check("rst_busy1", busy1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // N_OUT=1 cycle-exact drain with out_ready held high
    rdy1 = 1'b1;
    ack1 = 1'b1;
    @(negedge clk);
    check("n1_busy", busy1, 1);
    check("n1_trig", trig1, 1);
    @(negedge clk);
    check("n1_wait_valid", valid1, 0);
    check("n1_wait_trig", trig1, 0);
    @(negedge clk);
    check("n1_valid", valid1, 1);
    check("n1_data", data1, 16);
    check("n1_last", last1, 1);
    check("n1_index", idx1, 0);
    @(negedge clk);
    check("n1_done", done1, 1);
    check("n1_valid_off", valid1, 0);
`ifdef NN_OUT_ARGMAX_EN
    check("n1_class_value", cval1, 16);
    check("n1_class_index", ci1, 0);
`endif
    @(negedge clk);
    check("n1_done_clear", done1, 0);
    check("n1_busy_clear", busy1, 0);
    rdy1 = 1'b0;

    // Stalled word with a duplicated maximum
    mem4 = '{-8'sd8, 8'sd40, 8'sd12, 8'sd40};
    drain4(1, 5, 1'b0, 1'b0);

    // ack_network still high: no new drain may start
    busy_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy4) busy_seen = 1;
    end
    check("held_ack_no_restart", busy_seen, 0);

    // All-negative outputs: signed compare, lowest index wins the tie
    mem4 = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
    drain4(-1, 0, 1'b0, 1'b0);

    // Randomized contents and back-pressure
    repeat (4) begin
      for (int i = 0; i < 4; i++) mem4[i] = 8'($urandom_range(0, 255));
      drain4(-1, 0, 1'b1, 1'b0);
    end

    // Overrun: second rising edge while word 2 is on offer
    for (int i = 0; i < 4; i++) mem4[i] = 8'($urandom_range(0, 255));
    drain4(-1, 0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("overrun_sticky", ovr4, 1);
    check("overrun_no_redrain", busy4, 0);

    // Reset during SEND of word 2
    ack4 = 1'b0;
    @(negedge clk);
    ack4 = 1'b1;
    for (int w = 0; w < 3; w++) begin
      int t = 0;
      while (!valid4 && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("rst_mid_valid_seen", valid4, 1);
      if (w < 2) begin
        rdy4 = 1'b1;
        @(negedge clk);
        rdy4 = 1'b0;
      end
    end
    check("rst_mid_index", idx4, 2);
    ack4 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_valid", valid4, 0);
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    check("abort_overrun", ovr4, 0);
    ov_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) mem4[i] = 8'($urandom_range(0, 255));
    drain4(2, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
